cpu_ad48_lsu: RTL and testbench
===============================

// Module: cpu_ad48_lsu
// PURPOSE
//  Load/store unit between the cpu_ad48 execute stage and the DMEM port.
//  Accepts one LD/ST op at a time and computes EA = base + sext(disp33).
//  Performs the word access over a req/ack memory handshake.
//  Returns load data to the D register file and the post-inc result to the A register file.
// PARAMETERS
//  DM_WORDS  128  data memory depth in 48-bit words
//  ADDR_W    7    DMEM word-address width, $clog2(DM_WORDS)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-high reset
//  req_valid    in   1       op offered by execute
//  req_ready    out  1       LSU can accept (IDLE)
//  req_store    in   1       1=ST, 0=LD
//  req_postinc  in   1       write EA back to A[req_ra]
//  req_ra       in   3       base A-register index
//  req_base     in   48      value of A[req_ra]
//  req_disp     in   33      signed displacement (disp33)
//  req_rd       in   3       LD destination / ST source D index
//  req_sdata    in   48      store data (D[req_rd])
//  mem_req      out  1       DMEM request, held until ack
//  mem_we       out  1       write enable, valid with mem_req
//  mem_addr     out  ADDR_W  word address
//  mem_wdata    out  48      store data
//  mem_ack      in   1       DMEM completes access this cycle
//  mem_rdata    in   48      load data, valid with mem_ack
//  wb_d_valid   out  1       one-cycle D write pulse
//  wb_d_idx     out  3       D index
//  wb_d_data    out  48      load result
//  wb_a_valid   out  1       one-cycle A write pulse
//  wb_a_idx     out  3       A index
//  wb_a_data    out  48      EA for post-inc
//  busy         out  1       op in flight (state != IDLE)
//  fault        out  1       bounds fault pulse (CPU_AD48_LSU_BOUNDS_EN only, else 0)
// BEHAVIOUR
//  - Reset values: all outputs 0 except req_ready=1; FSM=IDLE; latched op cleared.
//  - FSM states:
//    - IDLE: req_ready=1. On req_valid, latch the op, compute EA (48-bit modular add), go to REQ.
//    - REQ: mem_req=1 with mem_we/mem_addr/mem_wdata stable. Hold until mem_ack. On ack, capture mem_rdata (LD) and go to WB.
//    - WB: pulse the writebacks for one cycle, then go to IDLE.
//  - Latency: a zero-wait ack gives accept at T, mem_req at T+1, WB at T+2, ready at T+3.
//  - WB pulses:
//    - wb_d_valid: LD only.
//    - wb_a_valid: req_postinc && req_ra!=0, for LD and ST.
//    - A0 post-inc is silently dropped (A0 is hard-wired zero).
//  - Both wb pulses may assert in the same cycle, e.g. LD D3,(A1+2)+ gives D3 and A1.
//  - mem_addr = EA[ADDR_W-1:0]; the upper EA bits are ignored (wrap) unless bounds checking is enabled.
//  - Negative disp: EA = base - |disp|, e.g. base 4, disp -1 -> EA 3.
//  - req_valid outside IDLE is ignored; execute must hold it until req_ready.
//  - Reset asserted mid-op: mem_req drops immediately (async) and the op is discarded with no writeback.
//  - A mem_ack that arrives outside REQ is ignored.
// CONFIGURATION
//  CPU_AD48_LSU_BOUNDS_EN defined:
//  - If EA >= DM_WORDS or EA[47]=1, go IDLE->WB with no mem_req issued.
//  - In that WB cycle: fault=1, wb_d_valid=0; the post-inc A writeback still occurs.
//  CPU_AD48_LSU_BOUNDS_EN undefined:
//  - fault is tied to 0 and the address wraps modulo 2^ADDR_W.
// TESTING
//  - LD, base 0, disp 1, DMEM[1]=200, zero-wait ack -> wb_d_valid at T+2, data 200, wb_a_valid=0.
//  - LD+, ra=1, base 2, disp 2, DMEM[4]=500 -> D=500 and A1=4 in the same WB cycle.
//  - ST+, ra=1, base 4, disp -2, sdata 12345 -> mem_we=1, addr 2, wdata 12345, A1=2, no D wb.
//  - LD+, ra=0, base 0, disp 2 -> reads addr 2, wb_a_valid stays 0.
//  - ack delayed 5 cycles -> mem_req/addr stable throughout, req_ready=0, single WB pulse.
//  - reset mid-REQ -> mem_req=0 and busy=0 at once, no WB; next op runs normally.
//  - BOUNDS_EN, base 120, disp 10 -> no mem_req, fault pulse, wb_d_valid=0.

Source files
------------

// File: rtl/cpu_ad48_lsu.sv
// cpu_ad48_lsu: load/store unit computing EA = base + sext(disp33) and doing one DMEM word access per op
// Ports: req_* op offered by execute (taken while req_ready), mem_* DMEM req/ack port,
//        wb_d_* load result to the D file, wb_a_* post-inc EA to the A file, busy/fault status.
// Option: define CPU_AD48_LSU_BOUNDS_EN to fault on EA >= DM_WORDS (no DMEM access) instead of wrapping.
module cpu_ad48_lsu #(
  parameter int DM_WORDS = 128,
  parameter int ADDR_W = $clog2(DM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic              req_postinc,
  input  logic [2:0]        req_ra,
  input  logic [47:0]       req_base,
  input  logic [32:0]       req_disp,
  input  logic [2:0]        req_rd,
  input  logic [47:0]       req_sdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [47:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [47:0]       mem_rdata,
  output logic              wb_d_valid,
  output logic [2:0]        wb_d_idx,
  output logic [47:0]       wb_d_data,
  output logic              wb_a_valid,
  output logic [2:0]        wb_a_idx,
  output logic [47:0]       wb_a_data,
  output logic              busy,
  output logic              fault
);
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
  state_t state;
  logic st, pi, oob;
  logic [2:0] ra, rd;
  logic [47:0] ea, sd, ea_n;
  assign ea_n = req_base + {{15{req_disp[32]}}, req_disp};
`ifdef CPU_AD48_LSU_BOUNDS_EN
  assign oob = ea_n >= 48'(DM_WORDS) || ea_n[47];
`else
  assign oob = 1'b0;
`endif
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign mem_req = state == REQ;
  assign mem_we = mem_req && st;
  assign mem_addr = ea[ADDR_W-1:0];
  assign mem_wdata = sd;
  assign wb_d_idx = rd;
  assign wb_a_idx = ra;
  assign wb_a_data = ea;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      st <= 1'b0;
      pi <= 1'b0;
      ra <= 3'd0;
      rd <= 3'd0;
      ea <= 48'd0;
      sd <= 48'd0;
      wb_d_valid <= 1'b0;
      wb_d_data <= 48'd0;
      wb_a_valid <= 1'b0;
      fault <= 1'b0;
    end else begin
      wb_d_valid <= 1'b0;
      wb_a_valid <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          st <= req_store;
          pi <= req_postinc;
          ra <= req_ra;
          rd <= req_rd;
          ea <= ea_n;
          sd <= req_sdata;
          state <= oob ? WB : REQ;
          // out-of-bounds ops skip DMEM; their WB cycle is produced directly from here
          fault <= oob;
          wb_a_valid <= oob && req_postinc && req_ra != 3'd0;
        end
        REQ: if (mem_ack) begin
          state <= WB;
          wb_d_valid <= !st;
          wb_d_data <= mem_rdata;
          wb_a_valid <= pi && ra != 3'd0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cpu_ad48_lsu.sv
// tb_cpu_ad48_lsu: directed + randomized bench with a transaction-level LSU/DMEM model
module tb_cpu_ad48_lsu;
  localparam int DMW = 128;
  localparam int AW = 7;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_store = 1'b0, req_postinc = 1'b0;
  logic [2:0] req_ra = 3'd0, req_rd = 3'd0;
  logic [47:0] req_base = 48'd0, req_sdata = 48'd0;
  logic [32:0] req_disp = 33'd0;
  logic mem_ack = 1'b0;
  logic [47:0] mem_rdata = 48'd0;
  logic req_ready, mem_req, mem_we, wb_d_valid, wb_a_valid, busy, fault;
  logic [AW-1:0] mem_addr;
  logic [47:0] mem_wdata, wb_d_data, wb_a_data;
  logic [2:0] wb_d_idx, wb_a_idx;

  cpu_ad48_lsu #(.DM_WORDS(DMW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store), .req_postinc(req_postinc),
    .req_ra(req_ra), .req_base(req_base), .req_disp(req_disp), .req_rd(req_rd), .req_sdata(req_sdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_d_valid(wb_d_valid), .wb_d_idx(wb_d_idx), .wb_d_data(wb_d_data),
    .wb_a_valid(wb_a_valid), .wb_a_idx(wb_a_idx), .wb_a_data(wb_a_data),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] ea_of(input logic [47:0] base, input logic [32:0] disp);
    longint s;
    s = longint'(base) + longint'($signed(disp));
    return s[47:0];
  endfunction

  function automatic logic is_oob(input logic [47:0] ea);
`ifdef CPU_AD48_LSU_BOUNDS_EN
    return ea >= 48'(DMW);
`else
    return 1'b0;
`endif
  endfunction

  // model: phase 0 = ready, 1 = DMEM access outstanding, 2 = writeback cycle
  logic [47:0] mem [DMW];
  int ph = 0, nph = 0, w = 0, dly = 0, cyc = 0, acc_cnt = 0, done_cnt = 0, acc_cyc = 0;
  bit spur = 0;
  logic m_st = 0, m_pi = 0, m_oob = 0;
  logic [2:0] m_ra = 0, m_rd = 0;
  logic [47:0] m_ea = 0, m_sd = 0, m_ld = 0;
  int o_nreq, o_nd, o_na, o_nf, o_first_req, o_wb_cyc;
  logic o_we, o_both;
  logic [47:0] o_d, o_a, o_addr, o_wd;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      ph = 0;
      nph = 0;
      mem_ack = 1'b0;
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_wb_d_valid", wb_d_valid, 0);
      chk("rst_wb_a_valid", wb_a_valid, 0);
      chk("rst_wb_a_data", wb_a_data, 0);
      chk("rst_wb_d_data", wb_d_data, 0);
      chk("rst_fault", fault, 0);
    end else begin
      if (ph == 2 && nph == 0) done_cnt++;
      ph = nph;
      chk("req_ready", req_ready, ph == 0);
      chk("busy", busy, ph != 0);
      chk("mem_req", mem_req, ph == 1);
      chk("wb_d_valid", wb_d_valid, ph == 2 && !m_st && !m_oob);
      chk("wb_a_valid", wb_a_valid, ph == 2 && m_pi && m_ra != 0);
      chk("fault", fault, ph == 2 && m_oob);
      if (ph == 1) begin
        chk("mem_addr", mem_addr, m_ea % DMW);
        chk("mem_we", mem_we, m_st);
        if (m_st) chk("mem_wdata", mem_wdata, m_sd);
        if (o_first_req < 0) begin
          o_first_req = cyc;
          o_addr = mem_addr;
          o_wd = mem_wdata;
        end
        o_nreq++;
        o_we |= mem_we;
      end
      if (ph == 2) o_wb_cyc = cyc;
      if (wb_d_valid) begin
        o_nd++;
        o_d = wb_d_data;
        if (ph == 2) begin
          chk("wb_d_idx", wb_d_idx, m_rd);
          chk("wb_d_data", wb_d_data, m_ld);
        end
      end
      if (wb_a_valid) begin
        o_na++;
        o_a = wb_a_data;
        if (ph == 2) begin
          chk("wb_a_idx", wb_a_idx, m_ra);
          chk("wb_a_data", wb_a_data, m_ea);
        end
      end
      if (wb_d_valid && wb_a_valid) o_both = 1;
      if (fault) o_nf++;
      mem_ack = 1'b0;
      mem_rdata = {$urandom, $urandom};
      nph = ph == 2 ? 0 : ph;
      if (ph == 0 && req_valid) begin
        m_st = req_store;
        m_pi = req_postinc;
        m_ra = req_ra;
        m_rd = req_rd;
        m_sd = req_sdata;
        m_ea = ea_of(req_base, req_disp);
        m_oob = is_oob(m_ea);
        nph = m_oob ? 2 : 1;
        w = 0;
        acc_cnt++;
        acc_cyc = cyc;
      end else if (ph == 1) begin
        if (w >= dly) begin
          mem_ack = 1'b1;
          if (m_st) mem[m_ea % DMW] = m_sd;
          else begin
            m_ld = mem[m_ea % DMW];
            mem_rdata = m_ld;
          end
          nph = 2;
        end else w++;
      end
      if (ph != 1 && spur && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
    end
  end

  task automatic op(input logic st, input logic pi, input logic [2:0] ra, input logic [2:0] rd,
                    input logic [47:0] base, input logic [32:0] disp, input logic [47:0] sd, input int d);
    int a0, d0, t;
    @(posedge clk);
    #2;
    dly = d;
    o_nreq = 0; o_nd = 0; o_na = 0; o_nf = 0; o_first_req = -1; o_wb_cyc = -1;
    o_we = 0; o_both = 0; o_d = 0; o_a = 0; o_addr = 0; o_wd = 0;
    a0 = acc_cnt;
    d0 = done_cnt;
    req_valid = 1; req_store = st; req_postinc = pi; req_ra = ra; req_rd = rd;
    req_base = base; req_disp = disp; req_sdata = sd;
    t = 0;
    while (acc_cnt == a0 && t < 50) begin
      @(posedge clk); #2; t++;
    end
    if (acc_cnt == a0) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
    // junk offer while busy must be ignored
    req_valid = 1; req_store = 1'($urandom); req_postinc = 1'($urandom); req_ra = 3'($urandom);
    req_base = {$urandom, $urandom}; req_disp = {$urandom, $urandom};
    @(posedge clk); #2;
    req_valid = 0;
    t = 0;
    while (done_cnt == d0 && t < 100) begin
      @(posedge clk); #2; t++;
    end
    if (done_cnt == d0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no completion expected completion within 100 cycles");
    end
  endtask

  initial begin
    for (int i = 0; i < DMW; i++) mem[i] = {$urandom, $urandom};
    mem[1] = 48'd200;
    mem[4] = 48'd500;
    repeat (3) @(posedge clk);
    #2 reset = 0;

    op(0, 0, 3'd0, 3'd3, 48'd0, 33'd1, 48'd0, 0);
    chk("t1_model_ea", m_ea, 1);
    chk("t1_d", o_d, 200);
    chk("t1_nd", o_nd, 1);
    chk("t1_na", o_na, 0);
    chk("t1_req_lat", 48'(o_first_req - acc_cyc), 1);
    chk("t1_wb_lat", 48'(o_wb_cyc - o_first_req), 1);

    op(0, 1, 3'd1, 3'd5, 48'd2, 33'd2, 48'd0, 1);
    chk("t2_d", o_d, 500);
    chk("t2_a", o_a, 4);
    chk("t2_both", o_both, 1);

    op(1, 1, 3'd1, 3'd2, 48'd4, 33'h1_FFFF_FFFE, 48'd12345, 0);
    chk("t3_we", o_we, 1);
    chk("t3_addr", o_addr, 2);
    chk("t3_wdata", o_wd, 12345);
    chk("t3_a", o_a, 2);
    chk("t3_nd", o_nd, 0);

    op(0, 1, 3'd0, 3'd1, 48'd0, 33'd2, 48'd0, 0);
    chk("t4_addr", o_addr, 2);
    chk("t4_d", o_d, 12345);
    chk("t4_na", o_na, 0);

    op(0, 0, 3'd2, 3'd4, 48'd4, 33'h1_FFFF_FFFF, 48'd0, 0);
    chk("t5_addr", o_addr, 3);

    op(0, 0, 3'd2, 3'd6, 48'd0, 33'd4, 48'd0, 5);
    chk("t6_nreq", o_nreq, 6);
    chk("t6_nd", o_nd, 1);
    chk("t6_d", o_d, 500);

    // reset in the middle of an outstanding access
    @(posedge clk); #2;
    dly = 8;
    o_nd = 0; o_na = 0;
    req_valid = 1; req_store = 0; req_postinc = 1; req_ra = 3'd1; req_rd = 3'd1;
    req_base = 48'd0; req_disp = 33'd4;
    @(posedge clk); #2;
    req_valid = 0;
    @(posedge clk); #2;
    chk("t7_pre_req", mem_req, 1);
    #1 reset = 1;
    #1;
    chk("t7_req_drop", mem_req, 0);
    chk("t7_busy_drop", busy, 0);
    @(posedge clk); #2 reset = 0;
    repeat (10) @(posedge clk);
    chk("t7_no_wb", 48'(o_nd + o_na), 0);
    op(0, 0, 3'd0, 3'd2, 48'd0, 33'd1, 48'd0, 0);
    chk("t7_after_d", o_d, 200);

    op(0, 1, 3'd3, 3'd1, 48'd120, 33'd10, 48'd0, 0);
`ifdef CPU_AD48_LSU_BOUNDS_EN
    chk("t8_nreq", o_nreq, 0);
    chk("t8_fault", o_nf, 1);
    chk("t8_nd", o_nd, 0);
    chk("t8_a", o_a, 130);
`else
    chk("t8_addr", o_addr, 2);
    chk("t8_fault", o_nf, 0);
    chk("t8_a", o_a, 130);
`endif

    spur = 1;
    for (int i = 0; i < 60; i++) begin
      logic [47:0] b;
      logic [32:0] dp;
      b = $urandom_range(0, 3) == 0 ? {$urandom, $urandom} : 48'($urandom_range(0, 300));
      dp = $urandom_range(0, 3) == 0 ? {$urandom, $urandom} : 33'($signed($urandom_range(0, 200)) - 100);
      op(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), b, dp, {$urandom, $urandom},
         int'($urandom_range(0, 3)));
    end
    spur = 0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
